product_acc: RTL and testbench
==============================

PRODUCT_ACC -- requirements
Module: product_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 4: multiplier operand width; products are 2*WIDTH bits.
REQ-002 SHALL have parameter COUNT, default 4: products summed per batch; legal range 2..256.
REQ-003 SHALL have parameter ACC_W, default 2*WIDTH+2: accumulator and result width; ACC_W >= 2*WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port clr, input, 1 bit: synchronous batch abort.
REQ-007 SHALL have port in_valid, input, 1 bit: in_prod holds a product.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a product this cycle.
REQ-009 SHALL have port in_prod, input, 2*WIDTH bits: unsigned product from the upstream multiplier.
REQ-010 SHALL have port out_valid, output, 1 bit: out_sum holds a completed batch sum.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes out_sum.
REQ-012 SHALL have port out_sum, output, ACC_W bits: sum of COUNT products, modulo 2^ACC_W.
REQ-013 SHALL have port out_ovf, output, 1 bit, present only with PRODUCT_ACC_OVF_EN: batch overflowed.

Function
REQ-014 SHALL implement a two-state FSM, ACCUM and DONE.
REQ-015 SHALL drive in_ready = 1 in ACCUM and 0 in DONE, combinationally from state only and independent of in_valid.
REQ-016 SHALL treat an accept as in_valid & in_ready; on accept, acc <= acc + zero-extended in_prod, truncated to ACC_W bits, and beat count increments.
REQ-017 SHALL, on the COUNT-th accept, load acc + in_prod into out_sum, clear acc and the count to 0, and move to DONE; out_valid rises the next cycle (latency 1 from the last accept).
REQ-018 SHALL hold out_sum and out_valid stable in DONE until out_valid & out_ready.
REQ-019 SHALL, on the output handshake, return to ACCUM with out_valid = 0 the next cycle; the next batch starts with acc = 0.
REQ-020 SHALL leave state, acc and count unchanged in any cycle without an accept.
REQ-021 SHALL, when clr = 1, zero acc and count, drop out_valid, and enter ACCUM next cycle from either state; an in_prod presented in the same cycle is discarded.
REQ-022 SHALL give priority rst > clr > handshakes.

Reset
REQ-023 SHALL, on rst = 1 at a clock edge, set state = ACCUM, acc = 0, count = 0, out_sum = 0, out_valid = 0, and out_ovf = 0 when present.
REQ-024 SHALL drive in_ready = 1 in the first cycle after rst deasserts; a partially accumulated batch is lost.

Configuration
REQ-025 SHALL, with macro PRODUCT_ACC_OVF_EN defined, track a sticky carry-out of the ACC_W-bit add across the batch, present it on out_ovf alongside out_sum, and clear it on handshake, clr and rst.
REQ-026 SHALL, without PRODUCT_ACC_OVF_EN, omit port out_ovf and all overflow logic; out_sum wraps silently.

Structure
REQ-027 SHALL place in shared package/header mul_pkg: FSM state encodings ST_ACCUM and ST_DONE, and the default WIDTH and COUNT constants.
REQ-028 SHALL split the beat counter into sub-module beat_counter.
  - Inputs: clk, rst, clr, inc.
  - Outputs: count, last; last = (count == COUNT-1).
  - Count width: clog2(COUNT).
REQ-029 SHALL keep the FSM and accumulator in product_acc; no other sub-modules.

Verification (WIDTH=4, COUNT=4, ACC_W=10 unless stated)
REQ-030 SHALL cover basic batch: products 1,2,3,4 on consecutive cycles with out_ready = 1 -> out_sum = 10, out_valid high one cycle after the 4th accept, then in_ready = 1.
REQ-031 SHALL cover maximum batch: four products of 225 -> out_sum = 900 with no wrap; with OVF_EN, out_ovf = 0.
REQ-032 SHALL cover backpressure: out_ready = 0 for 5 cycles after completion.
  - out_sum is held.
  - in_ready = 0 and an in_valid pulse is not accepted.
  - The next batch sums correctly after the handshake.
REQ-033 SHALL cover bubbles: in_valid toggling 1,0,0,1,1,0,1 with 7,9,11,13 presented on the valid cycles -> out_sum = 40.
REQ-034 SHALL cover mid-batch abort: clr after 2 accepts of 100, then 4 products of 5 -> out_sum = 20; rst mid-batch gives the same result as clr.
REQ-035 SHALL cover overflow (ACC_W=8, OVF_EN defined): four products of 200 -> out_sum = 800 mod 256 = 32, out_ovf = 1; the next batch of zeros gives out_ovf = 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants for the product accumulator: FSM state encodings and
// default operand width / batch length.
package mul_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_COUNT = 4;

endpackage

// File: rtl/product_acc_beat_counter.sv
// Beat counter for product_acc: counts accepted products within a batch and
// flags the final beat so the FSM can close the batch.
module beat_counter
    import mul_pkg::*;
#(
    parameter int COUNT = DEF_COUNT,
    parameter int CW    = $clog2(COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_VAL = CW'(COUNT - 1);

    assign last = (count == LAST_VAL);

    // Wrap explicitly on the last beat so non-power-of-two COUNT works.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/product_acc.sv
// Sums COUNT unsigned products per batch and hands the total downstream with
// a valid/ready handshake. Define PRODUCT_ACC_OVF_EN to add the out_ovf flag.
module product_acc
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int COUNT = DEF_COUNT,
    parameter int ACC_W = 2*WIDTH + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum
`ifdef PRODUCT_ACC_OVF_EN
    ,
    output logic               out_ovf
`endif
);

    localparam int CW = $clog2(COUNT);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CW-1:0]    count;
    logic             last;
    logic             accept;

    assign in_ready = (state == ST_ACCUM);
    assign accept   = in_valid & in_ready;

`ifdef PRODUCT_ACC_OVF_EN
    logic [ACC_W:0] sum_x;
    logic           carry;
    logic           ovf_acc;

    assign sum_x = {1'b0, acc} + (ACC_W+1)'(in_prod);
    assign sum   = sum_x[ACC_W-1:0];
    assign carry = sum_x[ACC_W];
`else
    assign sum = acc + ACC_W'(in_prod);
`endif

    beat_counter #(
        .COUNT (COUNT),
        .CW    (CW)
    ) u_beat (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (accept),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
`ifdef PRODUCT_ACC_OVF_EN
            ovf_acc   <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else if (clr) begin
            // Abort: any product presented this cycle is dropped.
            state     <= ST_ACCUM;
            acc       <= '0;
            out_valid <= 1'b0;
`ifdef PRODUCT_ACC_OVF_EN
            ovf_acc   <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            out_sum   <= sum;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            state     <= ST_DONE;
`ifdef PRODUCT_ACC_OVF_EN
                            out_ovf   <= ovf_acc | carry;
                            ovf_acc   <= 1'b0;
`endif
                        end else begin
                            acc <= sum;
`ifdef PRODUCT_ACC_OVF_EN
                            ovf_acc <= ovf_acc | carry;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
`ifdef PRODUCT_ACC_OVF_EN
                        out_ovf   <= 1'b0;
`endif
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    // count is consumed only through last; keep it observable for lint.
    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_product_acc.sv
// Directed self-checking bench for product_acc (WIDTH=4, COUNT=4, ACC_W=10);
// with PRODUCT_ACC_OVF_EN an ACC_W=8 copy shares the stimulus for overflow.
module tb_product_acc;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid, out_ready;
    logic [7:0] in_prod;
    logic       in_ready, out_valid;
    logic [9:0] out_sum;
    int         checks = 0;
    int         failures = 0;

`ifdef PRODUCT_ACC_OVF_EN
    logic       out_ovf;
    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_sum8;
`endif

    always #5 clk = ~clk;

    product_acc #(.WIDTH(4), .COUNT(4), .ACC_W(10)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef PRODUCT_ACC_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

`ifdef PRODUCT_ACC_OVF_EN
    product_acc #(.WIDTH(4), .COUNT(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready8), .in_prod(in_prod),
        .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
        .out_ovf(out_ovf8)
    );
`endif

    // One clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [7:0] p);
        in_valid = v;
        in_prod  = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_sum !== 10'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        beat(1'b1, 8'd1); beat(1'b1, 8'd2); beat(1'b1, 8'd3);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        beat(1'b1, 8'd4);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_sum !== 10'd10) begin failures++; $display("FAIL basic_sum got=%0d exp=10", out_sum); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_done_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_max();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(1'b1, 8'd225);
        checks++; if (out_sum !== 10'd900) begin failures++; $display("FAIL max_sum got=%0d exp=900", out_sum); end
`ifdef PRODUCT_ACC_OVF_EN
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL max_ovf got=%b exp=0", out_ovf); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(1'b1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_sum !== 10'd4) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/4", i, out_valid, out_sum); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            beat(i == 2, 8'd50);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid); end
        beat(1'b1, 8'd2); beat(1'b1, 8'd3); beat(1'b1, 8'd4); beat(1'b1, 8'd5);
        checks++; if (out_valid !== 1'b1 || out_sum !== 10'd14) begin failures++; $display("FAIL bp_next got=%b/%0d exp=1/14", out_valid, out_sum); end
        tick();
    endtask

    task automatic test_bubbles();
        logic [6:0] v;
        logic [7:0] p [7];
        v = 7'b1011001;   // bit i = cycle i: 1,0,0,1,1,0,1
        p = '{8'd7, 8'd99, 8'd99, 8'd9, 8'd11, 8'd99, 8'd13};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) beat(v[i], p[i]);
        checks++; if (out_valid !== 1'b1 || out_sum !== 10'd40) begin failures++; $display("FAIL bubbles got=%b/%0d exp=1/40", out_valid, out_sum); end
        tick();
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        beat(1'b1, 8'd100); beat(1'b1, 8'd100);
        clr = 1'b1; beat(1'b1, 8'd100); clr = 1'b0;
        for (int i = 0; i < 4; i++) beat(1'b1, 8'd5);
        checks++; if (out_valid !== 1'b1 || out_sum !== 10'd20) begin failures++; $display("FAIL clr_midbatch got=%b/%0d exp=1/20", out_valid, out_sum); end
        // Abort while a result is waiting.
        out_ready = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL clr_done got=%b/%b exp=0/1", out_valid, in_ready); end
        out_ready = 1'b1;
        beat(1'b1, 8'd100); beat(1'b1, 8'd100);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_sum !== 10'd0) begin failures++; $display("FAIL rst_midbatch got=%b/%0d exp=1/0", in_ready, out_sum); end
        for (int i = 0; i < 4; i++) beat(1'b1, 8'd5);
        checks++; if (out_valid !== 1'b1 || out_sum !== 10'd20) begin failures++; $display("FAIL rst_next got=%b/%0d exp=1/20", out_valid, out_sum); end
        tick();
    endtask

    task automatic test_overflow();
`ifdef PRODUCT_ACC_OVF_EN
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(1'b1, 8'd200);
        checks++; if (out_sum8 !== 8'd32 || out_ovf8 !== 1'b1) begin failures++; $display("FAIL ovf8 got=%0d/%b exp=32/1", out_sum8, out_ovf8); end
        checks++; if (out_sum !== 10'd800 || out_ovf !== 1'b0) begin failures++; $display("FAIL ovf10 got=%0d/%b exp=800/0", out_sum, out_ovf); end
        tick();
        checks++; if (out_ovf8 !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", out_ovf8); end
        for (int i = 0; i < 4; i++) beat(1'b1, 8'd0);
        checks++; if (out_valid8 !== 1'b1 || out_sum8 !== 8'd0 || out_ovf8 !== 1'b0) begin failures++; $display("FAIL ovf_zero got=%b/%0d/%b exp=1/0/0", out_valid8, out_sum8, out_ovf8); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_bubbles();
        test_clr();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
